// File: rtl/rf_write_arbiter_if.sv
// Writeback request / register-file write port bundle for rf_write_arbiter.
// master = pipeline side (requesters + observer), slave = the arbiter.
interface rf_write_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ID_W   = 5
);
  logic              hold;
  logic              req0_valid;
  logic              req0_ready;
  logic [ID_W-1:0]   req0_id;
  logic [DATA_W-1:0] req0_data;
  logic              req1_valid;
  logic              req1_ready;
  logic [ID_W-1:0]   req1_id;
  logic [DATA_W-1:0] req1_data;
  logic              write_en;
  logic [ID_W-1:0]   write_id;
  logic [DATA_W-1:0] write_data;
  logic              boost;
  logic              drop_x0;

  modport master (
    output hold, req0_valid, req0_id, req0_data, req1_valid, req1_id, req1_data,
    input  req0_ready, req1_ready, write_en, write_id, write_data, boost, drop_x0
  );

  modport slave (
    input  hold, req0_valid, req0_id, req0_data, req1_valid, req1_id, req1_data,
    output req0_ready, req1_ready, write_en, write_id, write_data, boost, drop_x0
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// Two-requester arbiter for the register file write port: req0 has fixed
// priority, a saturating wait counter boosts req1 after MAX_WAIT lost cycles.
module rf_write_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ID_W     = 5,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  rf_write_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  typedef enum logic {NORMAL, BOOST} state_t;

  state_t            state;
  logic [CNT_W-1:0]  wait_cnt;
  logic [CNT_W-1:0]  wait_nxt;
  logic              grant0;
  logic              grant1;
  logic              xfer;
  logic [ID_W-1:0]   sel_id;
  logic [DATA_W-1:0] sel_data;
  logic              write_en_q;
  logic [ID_W-1:0]   write_id_q;
  logic [DATA_W-1:0] write_data_q;
  logic              drop_x0_q;

  // Grants depend only on valid/hold/reset and the registered state.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!reset && !bus.hold) begin
      if (state == BOOST) begin
        grant1 = bus.req1_valid;
        grant0 = bus.req0_valid && !bus.req1_valid;
      end else begin
        grant0 = bus.req0_valid;
        grant1 = bus.req1_valid && !bus.req0_valid;
      end
    end
  end

  always_comb begin
    wait_nxt = '0;
    if (bus.req1_valid && !grant1)
      wait_nxt = (wait_cnt == CNT_MAX) ? wait_cnt : wait_cnt + CNT_W'(1);
  end

  assign xfer     = grant0 || grant1;
  assign sel_id   = grant1 ? bus.req1_id   : bus.req0_id;
  assign sel_data = grant1 ? bus.req1_data : bus.req0_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= NORMAL;
      wait_cnt     <= '0;
      write_en_q   <= 1'b0;
      write_id_q   <= '0;
      write_data_q <= '0;
      drop_x0_q    <= 1'b0;
    end else begin
      wait_cnt <= wait_nxt;
      case (state)
        NORMAL: if (wait_nxt == CNT_MAX) state <= BOOST;
        BOOST:  if (grant1 || !bus.req1_valid) state <= NORMAL;
        default: state <= NORMAL;
      endcase
      write_en_q <= xfer && (sel_id != '0);
      drop_x0_q  <= xfer && (sel_id == '0);
      if (xfer && (sel_id != '0)) begin
        write_id_q   <= sel_id;
        write_data_q <= sel_data;
      end
    end
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign bus.write_en   = write_en_q;
  assign bus.write_id   = write_id_q;
  assign bus.write_data = write_data_q;
  assign bus.drop_x0    = drop_x0_q;
  assign bus.boost      = (state == BOOST);
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Randomized + directed bench for rf_write_arbiter against a lost-cycle
// reference model and a register-file scoreboard.
module tb_rf_write_arbiter;
  localparam int DATA_W   = 32;
  localparam int ID_W     = 5;
  localparam int MAX_WAIT = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  rf_write_arbiter_if #(.DATA_W(DATA_W), .ID_W(ID_W)) bus ();

  rf_write_arbiter #(.DATA_W(DATA_W), .ID_W(ID_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: consecutive cycles req1 was valid but not accepted.
  int                lost = 0;
  logic              m_we = 1'b0, m_drop = 1'b0;
  logic [ID_W-1:0]   m_id = '0;
  logic [DATA_W-1:0] m_data = '0;
  logic              x0 = 1'b0, x1 = 1'b0;
  logic [DATA_W-1:0] rf_model [32];
  logic [DATA_W-1:0] rf_dut   [32];

  always @(posedge clk)
    if (bus.write_en) rf_dut[bus.write_id] <= bus.write_data;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic cycle();
    logic e0, e1, boosted;
    logic [ID_W-1:0] id;
    logic [DATA_W-1:0] data;
    @(negedge clk);
    boosted = (lost >= MAX_WAIT);
    e0 = !reset && !bus.hold && bus.req0_valid && (!boosted || !bus.req1_valid);
    e1 = !reset && !bus.hold && bus.req1_valid && (boosted || !bus.req0_valid);
    check_eq("req0_ready", 32'(bus.req0_ready), 32'(e0));
    check_eq("req1_ready", 32'(bus.req1_ready), 32'(e1));
    check_eq("boost",      32'(bus.boost),      32'(boosted));
    check_eq("write_en",   32'(bus.write_en),   32'(m_we));
    check_eq("drop_x0",    32'(bus.drop_x0),    32'(m_drop));
    check_eq("write_id",   32'(bus.write_id),   32'(m_id));
    check_eq("write_data", bus.write_data,      m_data);
    x0 = bus.req0_valid && e0;
    x1 = bus.req1_valid && e1;
    if (reset) begin
      m_we = 1'b0; m_drop = 1'b0; m_id = '0; m_data = '0; lost = 0;
    end else begin
      m_we = 1'b0;
      m_drop = 1'b0;
      if (x0 || x1) begin
        id   = x1 ? bus.req1_id : bus.req0_id;
        data = x1 ? bus.req1_data : bus.req0_data;
        if (id == '0) m_drop = 1'b1;
        else begin
          m_we = 1'b1; m_id = id; m_data = data; rf_model[id] = data;
        end
      end
      lost = (bus.req1_valid && !x1) ? lost + 1 : 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic v, input logic [ID_W-1:0] id, input logic [DATA_W-1:0] d);
    bus.req0_valid = v; bus.req0_id = id; bus.req0_data = d;
  endtask

  task automatic set1(input logic v, input logic [ID_W-1:0] id, input logic [DATA_W-1:0] d);
    bus.req1_valid = v; bus.req1_id = id; bus.req1_data = d;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      rf_model[i] = '0;
      rf_dut[i]   = '0;
    end
    bus.hold = 1'b0;
    set0(1'b0, '0, '0);
    set1(1'b0, '0, '0);
    @(posedge clk);
    #1;
    cycle();
    cycle();
    reset = 1'b0;

    // single writes
    set0(1'b1, 5'd5, 32'hDEADBEEF); cycle();
    set0(1'b0, '0, '0);             cycle();
    set1(1'b1, 5'd31, 32'h1);       cycle();
    set1(1'b0, '0, '0);             cycle();

    // conflict: both continuously valid
    set0(1'b1, 5'd3, $urandom);
    set1(1'b1, 5'd4, $urandom);
    for (int n = 0; n < 12; n++) begin
      cycle();
      if (x0) bus.req0_data = $urandom;
      if (x1) bus.req1_data = $urandom;
    end
    set0(1'b0, '0, '0);
    set1(1'b0, '0, '0);
    cycle();

    // x0 drop
    set1(1'b1, 5'd0, 32'hFFFFFFFF); cycle();
    set1(1'b0, '0, '0);             cycle();

    // hold with both valid, then release
    set0(1'b1, 5'd10, 32'h1010);
    set1(1'b1, 5'd11, 32'h1111);
    bus.hold = 1'b1;
    for (int n = 0; n < 6; n++) cycle();
    bus.hold = 1'b0;
    cycle();
    check_eq("hold_release_req1_first", 32'(x1), 32'd1);
    set1(1'b0, '0, '0);
    cycle();
    set0(1'b0, '0, '0);
    cycle();

    // reset mid-operation
    set0(1'b1, 5'd12, 32'hAAAA0001); cycle();
    set0(1'b1, 5'd13, 32'hAAAA0002);
    reset = 1'b1;                    cycle();
    reset = 1'b0;                    cycle();
    set0(1'b0, '0, '0);              cycle();
    cycle();

    // same-id collision
    set0(1'b1, 5'd7, 32'hA);
    set1(1'b1, 5'd7, 32'hB);
    cycle();
    if (x0) set0(1'b0, '0, '0);
    cycle();
    if (x1) set1(1'b0, '0, '0);
    cycle();
    cycle();
    check_eq("collision_rf7", rf_dut[7], 32'hB);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      if (x0 || !bus.req0_valid)
        set0(($urandom_range(0, 3) != 0), ID_W'($urandom_range(0, 31)), $urandom);
      if (x1 || !bus.req1_valid)
        set1(($urandom_range(0, 3) != 0), ID_W'($urandom_range(0, 31)), $urandom);
      bus.hold = ($urandom_range(0, 7) == 0);
      reset    = ($urandom_range(0, 99) == 0);
      cycle();
    end
    reset = 1'b0;
    bus.hold = 1'b0;
    set0(1'b0, '0, '0);
    set1(1'b0, '0, '0);
    cycle();
    cycle();

    for (int i = 0; i < 32; i++)
      check_eq($sformatf("rf[%0d]", i), rf_dut[i], rf_model[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
